// File: rtl/demux2_reg_if.sv
// Stream bundle for demux2_reg: one input stream, two output streams.
// master = producer/consumer side, slave = the demux itself.
interface demux2_reg_if #(
  parameter int BUS_WIDTH = 32
);
  logic                 selector;
  logic                 in_valid;
  logic                 in_ready;
  logic [BUS_WIDTH-1:0] in_data;
  logic                 out0_valid;
  logic                 out0_ready;
  logic [BUS_WIDTH-1:0] out0_data;
  logic                 out1_valid;
  logic                 out1_ready;
  logic [BUS_WIDTH-1:0] out1_data;

  modport master (
    output selector, in_valid, in_data, out0_ready, out1_ready,
    input  in_ready, out0_valid, out0_data, out1_valid, out1_data
  );

  modport slave (
    input  selector, in_valid, in_data, out0_ready, out1_ready,
    output in_ready, out0_valid, out0_data, out1_valid, out1_data
  );
endinterface

// File: rtl/demux2_reg.sv
// demux2_reg: registered 1:2 stream demux. Each destination owns a one-entry
// slot, so outputs are registered and each path sustains 1 word/cycle.
// Optional pop counters enabled with `define DEMUX2_COUNT_EN.
module demux2_reg #(
  parameter int BUS_WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  demux2_reg_if.slave bus
`ifdef DEMUX2_COUNT_EN
  ,
  output logic [15:0] count0,
  output logic [15:0] count1
`endif
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} slot_e;

  slot_e                     st     [2];
  slot_e                     st_nxt [2];
  logic [1:0][BUS_WIDTH-1:0] data_q;
  logic [1:0]                out_rdy;
  logic [1:0]                open_k;
  logic [1:0]                ld;
  logic [1:0]                pop;
  logic                      acc;

  assign out_rdy = {bus.out1_ready, bus.out0_ready};

  // A slot can take a word if it is empty or draining this cycle; only the
  // selected slot gates the input, so a stalled neighbour never blocks it.
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      open_k[k] = (st[k] == EMPTY) || out_rdy[k];
      pop[k]    = (st[k] == FULL) && out_rdy[k];
    end
  end

  assign bus.in_ready = !rst && (bus.selector ? open_k[1] : open_k[0]);
  assign acc          = bus.in_valid && bus.in_ready;
  assign ld           = {acc && bus.selector, acc && !bus.selector};

  // Per-slot next state: a load always wins over a pop (pop+load stays FULL).
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      st_nxt[k] = st[k];
      case (st[k])
        EMPTY: if (ld[k]) st_nxt[k] = FULL;
        FULL:  if (pop[k] && !ld[k]) st_nxt[k] = EMPTY;
      endcase
    end
  end

  // Slot state and data; data only changes on a load so it holds while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        st[k]     <= EMPTY;
        data_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        st[k] <= st_nxt[k];
        if (ld[k]) data_q[k] <= bus.in_data;
      end
    end
  end

  assign bus.out0_valid = (st[0] == FULL);
  assign bus.out1_valid = (st[1] == FULL);
  assign bus.out0_data  = data_q[0];
  assign bus.out1_data  = data_q[1];

`ifdef DEMUX2_COUNT_EN
  // Saturating pop counters, one per destination.
  always_ff @(posedge clk) begin
    if (rst) begin
      count0 <= '0;
      count1 <= '0;
    end else begin
      if (pop[0] && count0 != 16'hFFFF) count0 <= count0 + 16'd1;
      if (pop[1] && count1 != 16'hFFFF) count1 <= count1 + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_demux2_reg.sv
// Bench for demux2_reg: directed vector table, streaming loop, randomized run
// against a queue-based slot model, and counter checks when DEMUX2_COUNT_EN.
module tb_demux2_reg;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  demux2_reg_if #(.BUS_WIDTH(W)) bus ();

`ifdef DEMUX2_COUNT_EN
  logic [15:0] count0, count1;
`endif

  demux2_reg #(.BUS_WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus)
`ifdef DEMUX2_COUNT_EN
    ,
    .count0(count0),
    .count1(count1)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic iv, input logic sel,
                       input logic [31:0] d, input logic r0, input logic r1);
    rst            = r;
    bus.in_valid   = iv;
    bus.selector   = sel;
    bus.in_data    = d;
    bus.out0_ready = r0;
    bus.out1_ready = r1;
  endtask

  // One directed cycle: inputs, expected in_ready (same cycle),
  // expected slot outputs after the clock edge.
  typedef struct {
    logic        rst, iv, sel;
    logic [31:0] din;
    logic        r0, r1;
    logic        rdy;
    logic        v0;
    logic [31:0] d0;
    logic        v1;
    logic [31:0] d1;
  } vec_t;

  vec_t vt [16];

  // Queue model of the two depth-1 slots.
  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic [31:0] hold0, hold1;
  int          pc0, pc1;

  initial begin
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);

    //        rst iv sel din           r0 r1  rdy v0 d0            v1 d1
    vt[0]  = '{1, 0, 0, 32'h0,         0, 0,  0,  0, 32'h0,        0, 32'h0};
    // reset mid-hold
    vt[1]  = '{0, 1, 0, 32'hDEADBEEF,  0, 0,  1,  1, 32'hDEADBEEF, 0, 32'h0};
    vt[2]  = '{0, 0, 0, 32'h0,         0, 0,  0,  1, 32'hDEADBEEF, 0, 32'h0};
    vt[3]  = '{1, 1, 1, 32'h12345678,  0, 1,  0,  0, 32'h0,        0, 32'h0};
    vt[4]  = '{0, 0, 0, 32'h0,         1, 1,  1,  0, 32'h0,        0, 32'h0};
    // basic routing
    vt[5]  = '{0, 1, 0, 32'h11111111,  1, 1,  1,  1, 32'h11111111, 0, 32'h0};
    vt[6]  = '{0, 1, 1, 32'h22222222,  1, 1,  1,  0, 32'h11111111, 1, 32'h22222222};
    vt[7]  = '{0, 0, 0, 32'h0,         1, 1,  1,  0, 32'h11111111, 0, 32'h22222222};
    // backpressure / isolation
    vt[8]  = '{0, 1, 1, 32'hA5A5A5A5,  1, 0,  1,  0, 32'h11111111, 1, 32'hA5A5A5A5};
    vt[9]  = '{0, 1, 1, 32'h5A5A5A5A,  1, 0,  0,  0, 32'h11111111, 1, 32'hA5A5A5A5};
    vt[10] = '{0, 1, 0, 32'h0000CAFE,  0, 0,  1,  1, 32'h0000CAFE, 1, 32'hA5A5A5A5};
    vt[11] = '{0, 1, 1, 32'h5A5A5A5A,  1, 1,  1,  0, 32'h0000CAFE, 1, 32'h5A5A5A5A};
    vt[12] = '{0, 0, 0, 32'h0,         1, 1,  1,  0, 32'h0000CAFE, 0, 32'h5A5A5A5A};
    // simultaneous pop + load
    vt[13] = '{0, 1, 0, 32'h00000001,  0, 1,  1,  1, 32'h00000001, 0, 32'h5A5A5A5A};
    vt[14] = '{0, 1, 0, 32'h00000002,  1, 1,  1,  1, 32'h00000002, 0, 32'h5A5A5A5A};
    vt[15] = '{0, 0, 0, 32'h0,         1, 1,  1,  0, 32'h00000002, 0, 32'h5A5A5A5A};

    @(posedge clk); #1;

    for (int i = 0; i < 16; i++) begin
      drive(vt[i].rst, vt[i].iv, vt[i].sel, vt[i].din, vt[i].r0, vt[i].r1);
      #1;
      chk($sformatf("vec%0d in_ready", i), {31'b0, bus.in_ready}, {31'b0, vt[i].rdy});
      @(posedge clk); #1;
      chk($sformatf("vec%0d out0_valid", i), {31'b0, bus.out0_valid}, {31'b0, vt[i].v0});
      chk($sformatf("vec%0d out0_data", i),  bus.out0_data, vt[i].d0);
      chk($sformatf("vec%0d out1_valid", i), {31'b0, bus.out1_valid}, {31'b0, vt[i].v1});
      chk($sformatf("vec%0d out1_data", i),  bus.out1_data, vt[i].d1);
    end

    // streaming: 8 words back-to-back to out0, one per cycle
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b1, 1'b0, i, 1'b1, 1'b1);
      #1;
      chk($sformatf("stream%0d in_ready", i), {31'b0, bus.in_ready}, 32'd1);
      @(posedge clk); #1;
      chk($sformatf("stream%0d out0_valid", i), {31'b0, bus.out0_valid}, 32'd1);
      chk($sformatf("stream%0d out0_data", i), bus.out0_data, i);
    end

    // randomized run against the queue model, starting from reset
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    @(posedge clk); #1;
    q0.delete(); q1.delete();
    hold0 = '0; hold1 = '0; pc0 = 0; pc1 = 0;
    for (int c = 0; c < 2000; c++) begin
      logic r, iv, sel, r0, r1, erdy, acc, p0, p1;
      logic [31:0] d;
      r   = ($urandom_range(0, 31) == 0);
      iv  = ($urandom_range(0, 3) != 0);
      sel = 1'($urandom_range(0, 1));
      d   = $urandom;
      r0  = ($urandom_range(0, 3) != 0);
      r1  = ($urandom_range(0, 2) != 0);
      drive(r, iv, sel, d, r0, r1);
      #1;
      erdy = !r && (sel ? (q1.size() == 0 || r1) : (q0.size() == 0 || r0));
      chk("rand in_ready", {31'b0, bus.in_ready}, {31'b0, erdy});
      acc = iv && erdy;
      p0  = (q0.size() != 0) && r0;
      p1  = (q1.size() != 0) && r1;
      @(posedge clk); #1;
      if (r) begin
        q0.delete(); q1.delete();
        hold0 = '0; hold1 = '0; pc0 = 0; pc1 = 0;
      end else begin
        if (p0) begin void'(q0.pop_front()); if (pc0 < 65535) pc0++; end
        if (p1) begin void'(q1.pop_front()); if (pc1 < 65535) pc1++; end
        if (acc && !sel) begin q0.push_back(d); hold0 = d; end
        if (acc &&  sel) begin q1.push_back(d); hold1 = d; end
      end
      chk("rand out0_valid", {31'b0, bus.out0_valid}, {31'b0, q0.size() != 0});
      chk("rand out0_data", bus.out0_data, hold0);
      chk("rand out1_valid", {31'b0, bus.out1_valid}, {31'b0, q1.size() != 0});
      chk("rand out1_data", bus.out1_data, hold1);
`ifdef DEMUX2_COUNT_EN
      chk("rand count0", {16'b0, count0}, pc0);
      chk("rand count1", {16'b0, count1}, pc1);
`endif
    end

`ifdef DEMUX2_COUNT_EN
    // counter: 5 pops on out0, 3 on out1, then saturation
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    @(posedge clk); #1;
    chk("count0 reset", {16'b0, count0}, 32'd0);
    chk("count1 reset", {16'b0, count1}, 32'd0);
    drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
    repeat (5) @(posedge clk);
    #1 drive(1'b0, 1'b1, 1'b1, 32'h0, 1'b1, 1'b1);
    repeat (3) @(posedge clk);
    #1 drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    chk("count0 after 5", {16'b0, count0}, 32'd5);
    chk("count1 after 3", {16'b0, count1}, 32'd3);
    drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
    repeat (65529) @(posedge clk);
    #1 drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    chk("count0 FFFE", {16'b0, count0}, 32'h0000FFFE);
    drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
    repeat (3) @(posedge clk);
    #1 drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    chk("count0 saturate", {16'b0, count0}, 32'h0000FFFF);
    chk("count1 unchanged", {16'b0, count1}, 32'd3);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/demux2_reg.md
Name: demux2_reg

Overview:
- Registered 1:2 demultiplexer. It is the steering counterpart of the 2:1 bus mux.
- Takes one valid/ready stream and routes each word to one of two destination streams, chosen by a per-word selector.
- Each destination has a one-entry output slot, giving a registered boundary and sustained 1 word/cycle per destination.
- Used where one producer (e.g. a result bus) feeds two consumers (e.g. writeback path vs. store/forward path).

Parameters:
- BUS_WIDTH, 32, width of the data word on the input and both outputs.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- selector  input  1  destination for the current input word: 0 -> out0, 1 -> out1. Sampled only on an accepted transfer.
- in_valid  input  1  producer has a word on in_data.
- in_ready  output  1  block accepts the word this cycle.
- in_data  input  BUS_WIDTH  input word.
- out0_valid  output  1  slot 0 holds a word.
- out0_ready  input  1  consumer 0 takes the word this cycle.
- out0_data  output  BUS_WIDTH  slot 0 word.
- out1_valid  output  1  slot 1 holds a word.
- out1_ready  input  1  consumer 1 takes the word this cycle.
- out1_data  output  BUS_WIDTH  slot 1 word.

Behaviour:
- Transfer definitions:
  - Input transfer (acc) = in_valid && in_ready.
  - Output transfer k (popk) = outk_valid && outk_ready.
- Each slot k has two states: EMPTY (outk_valid=0) and FULL (outk_valid=1).
- in_ready is combinational: !rst && (selector ? (!out1_valid || out1_ready) : (!out0_valid || out0_ready)). It depends only on the selected slot. A full, stalled unselected slot never blocks the input.
- Slot k transitions per cycle:
  - EMPTY, acc to k -> FULL; outk_data <= in_data.
  - FULL, popk, no acc to k -> EMPTY; outk_data holds its value (don't-care, but must not change).
  - FULL, popk, acc to k -> FULL; outk_data <= in_data. This gives back-to-back throughput of 1/cycle.
  - FULL, no popk -> FULL; outk_data and outk_valid held stable. The bench checks stability.
  - EMPTY, no acc to k -> EMPTY.
- Latency: a word accepted in cycle N appears on outk_valid/outk_data in cycle N+1. There is no combinational path from in_data to outk_data.
- At most one slot loads per cycle. Both slots may pop in the same cycle.
- Ordering:
  - Per destination, strict FIFO order is guaranteed (depth 1).
  - No ordering is guaranteed between destinations.
- When in_valid=0, selector is ignored. in_ready may still toggle with selector; the producer must not depend on that.
- Reset (rst=1 at clk edge):
  - out0_valid=0, out1_valid=0, out0_data=0, out1_data=0.
  - in_ready=0 while rst=1.
  - Words held mid-operation are discarded and are not delivered after reset.
  - rst overrides any simultaneous acc or pop.
- Outputs never assert valid with X data after reset.

Optional Feature:
- Macro: DEMUX2_COUNT_EN.
- When defined, two extra ports are added:
  - count0  output  16  number of pop0 events since reset.
  - count1  output  16  number of pop1 events since reset.
- Counter rules:
  - Registered; increment by 1 on the cycle after the pop.
  - Saturate at 16'hFFFF; no wrap.
  - Reset to 0 on rst.
- When not defined, the ports and logic are absent. All other behaviour is identical in both builds.

Test Plan:
- Reset mid-hold: fill slot0 with 32'hDEADBEEF, hold out0_ready=0, assert rst one cycle -> next cycle out0_valid=0, out0_data=0; in_ready=0 during rst; after deassertion the word never appears.
- Basic routing: send 32'h11111111 with selector=0, then 32'h22222222 with selector=1, both consumers ready -> out0 shows 32'h11111111 the cycle after the first accept, out1 shows 32'h22222222 the cycle after the second; each valid is high for exactly 1 cycle.
- Streaming: out0_ready=1 constantly, 8 consecutive words 0..7 with selector=0 -> in_ready stays 1, out0_data = 0..7 on consecutive cycles, latency 1.
- Backpressure/isolation: out1_ready=0, send 32'hA5A5A5A5 to out1, then attempt 32'h5A5A5A5A to out1 and 32'h0000CAFE to out0 ->
  - in_ready=0 for the out1 attempt;
  - out1_data holds 32'hA5A5A5A5 stable;
  - the out0 word is accepted and delivered.
  - After releasing out1_ready, 32'h5A5A5A5A follows in order.
- Simultaneous pop+load: slot0 full with 32'h1, out0_ready=1, in_valid=1 selector=0 in_data=32'h2 -> in_ready=1; next cycle out0_valid=1, out0_data=32'h2; no bubble.
- DEMUX2_COUNT_EN build: 5 pops on out0, 3 on out1 -> count0=5, count1=3. Force count0 to 16'hFFFE, do 3 more pops -> count0=16'hFFFF.
